// File: rtl/conv_pool_relu.sv
// conv_pool_relu: 2x2 stride-2 max pooling, bias add with signed saturation
// and ReLU over a row-major partial-sum map, streamed out on valid/ready.
module conv_pool_relu #(
    parameter int DataWidth    = 32,
    parameter int AddrWidth    = 16,
    parameter int MaxPictWidth = 9,
    parameter int RdLatency    = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    start,
    input  logic [MaxPictWidth-1:0] row_in,
    input  logic [MaxPictWidth-1:0] col_in,
    input  logic [DataWidth-1:0]    bias_in,
    output logic [AddrWidth-1:0]    rd_addr,
    input  logic [DataWidth-1:0]    rd_data,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        IDLE, READ, DRAIN, CALC, OUT, FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [MaxPictWidth-1:0] r_rows;
    logic [MaxPictWidth-1:0] r_cols;
    logic [MaxPictWidth-1:0] r_pr;
    logic [MaxPictWidth-1:0] r_pc;
    logic [DataWidth-1:0]    r_bias;
    logic [DataWidth-1:0]    r_max;
    logic [DataWidth-1:0]    r_out;
    logic [AddrWidth-1:0]    r_row_base;
    logic [AddrWidth-1:0]    r_col_off;
    logic [AddrWidth-1:0]    r_addr;
    logic [1:0]              r_k;
    logic [2:0]              r_ns;
    logic [RdLatency-1:0]    r_vld;
    logic                    r_ovalid;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_start;
    logic                    w_small;
    logic                    w_issue;
    logic                    w_samp;
    logic                    w_got_all;
    logic                    w_hs;
    logic                    w_last_col;
    logic                    w_last;
    logic [MaxPictWidth-1:0] w_pr_max;
    logic [MaxPictWidth-1:0] w_pc_max;
    logic [AddrWidth-1:0]    w_w_ext;
    logic [AddrWidth-1:0]    w_pix;
    logic [AddrWidth-1:0]    w_rd_next;
    logic [AddrWidth-1:0]    w_nxt_row;
    logic [AddrWidth-1:0]    w_nxt_col;
    logic [RdLatency:0]      w_vld_sh;
    logic [DataWidth:0]      w_sum;
    logic [DataWidth-1:0]    w_sat;
    logic [DataWidth-1:0]    w_relu;

    // A start coinciding with the done pulse belongs to the finished pass.
    assign w_start    = start && (r_state == IDLE) && !r_done;
    assign w_small    = (row_in < MaxPictWidth'(2)) || (col_in < MaxPictWidth'(2));
    assign w_issue    = (r_state == READ);
    assign w_vld_sh   = {r_vld, w_issue};
    assign w_samp     = r_vld[RdLatency-1];
    assign w_got_all  = (r_ns == 3'd4) || (w_samp && (r_ns == 3'd3));
    assign w_hs       = (r_state == OUT) && r_ovalid && out_ready;

    assign w_pr_max   = (r_rows >> 1) - MaxPictWidth'(1);
    assign w_pc_max   = (r_cols >> 1) - MaxPictWidth'(1);
    assign w_last_col = (r_pc == w_pc_max);
    assign w_last     = w_last_col && (r_pr == w_pr_max);

    assign w_w_ext    = {{(AddrWidth-MaxPictWidth){1'b0}}, r_cols};
    assign w_pix      = r_row_base + r_col_off;
    assign w_nxt_row  = w_last_col ? r_row_base + (w_w_ext << 1) : r_row_base;
    assign w_nxt_col  = w_last_col ? '0 : r_col_off + AddrWidth'(2);

    always_comb begin
        w_rd_next = w_pix;
        unique case (r_k)
            2'd0:    w_rd_next = w_pix + AddrWidth'(1);
            2'd1:    w_rd_next = w_pix + w_w_ext;
            default: w_rd_next = w_pix + w_w_ext + AddrWidth'(1);
        endcase
    end

    // One extra bit holds the true sign of max + bias.
    assign w_sum = {r_max[DataWidth-1], r_max} + {r_bias[DataWidth-1], r_bias};

    always_comb begin
        w_sat = w_sum[DataWidth-1:0];
        if (w_sum[DataWidth] != w_sum[DataWidth-1]) begin
            w_sat = w_sum[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}}
                                     : {1'b0, {(DataWidth-1){1'b1}}};
        end
    end

    assign w_relu = w_sat[DataWidth-1] ? '0 : w_sat;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = w_small ? FIN : READ;
            READ:    if (r_k == 2'd3) w_next = DRAIN;
            DRAIN:   if (w_got_all) w_next = CALC;
            CALC:    w_next = OUT;
            OUT:     if (w_hs) w_next = w_last ? FIN : READ;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rows     <= '0;
            r_cols     <= '0;
            r_pr       <= '0;
            r_pc       <= '0;
            r_bias     <= '0;
            r_max      <= '0;
            r_out      <= '0;
            r_row_base <= '0;
            r_col_off  <= '0;
            r_addr     <= '0;
            r_k        <= '0;
            r_ns       <= '0;
            r_vld      <= '0;
            r_ovalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_vld  <= w_vld_sh[RdLatency-1:0];
            r_done <= (r_state == FIN);
            if (r_state == FIN) r_busy <= 1'b0;
            if (w_start) begin
                r_rows     <= row_in;
                r_cols     <= col_in;
                r_bias     <= bias_in;
                r_pr       <= '0;
                r_pc       <= '0;
                r_row_base <= '0;
                r_col_off  <= '0;
                r_busy     <= 1'b1;
                if (!w_small) begin
                    r_addr <= '0;
                    r_k    <= '0;
                    r_ns   <= '0;
                end
            end
            if (r_state == READ) begin
                r_k <= r_k + 2'd1;
                if (r_k != 2'd3) r_addr <= w_rd_next;
            end
            if (w_samp) begin
                r_ns <= r_ns + 3'd1;
                if ((r_ns == 3'd0) || ($signed(rd_data) > $signed(r_max))) begin
                    r_max <= rd_data;
                end
            end
            if (r_state == CALC) begin
                r_out    <= w_relu;
                r_ovalid <= 1'b1;
            end
            if (w_hs) begin
                r_ovalid   <= 1'b0;
                r_pc       <= w_last_col ? '0 : r_pc + MaxPictWidth'(1);
                r_row_base <= w_nxt_row;
                r_col_off  <= w_nxt_col;
                if (w_last_col) r_pr <= r_pr + MaxPictWidth'(1);
                if (!w_last) begin
                    r_addr <= w_nxt_row + w_nxt_col;
                    r_k    <= '0;
                    r_ns   <= '0;
                end
            end
        end
    end

    assign rd_addr   = r_addr;
    assign out_data  = r_out;
    assign out_valid = r_ovalid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_conv_pool_relu.sv
// tb_conv_pool_relu: directed passes over small maps; a negedge monitor
// pops expected pixels from a queue on every output handshake.
module tb_conv_pool_relu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  row_in;
    logic [8:0]  col_in;
    logic [31:0] bias_in;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:63];
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int ov_cnt = 0;
    int n;

    always #5 clk = ~clk;

    conv_pool_relu #(
        .DataWidth(32),
        .AddrWidth(16),
        .MaxPictWidth(9),
        .RdLatency(1)
    ) dut (
        .Clk(clk),
        .Rst(rst_n),
        .start(start),
        .row_in(row_in),
        .col_in(col_in),
        .bias_in(bias_in),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    // Registered-output RAM: one cycle of read latency.
    always @(posedge clk) rd_data <= mem[rd_addr[5:0]];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid) ov_cnt++;
        if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_extra got=%h req=none", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL out_pixel got=%h req=%h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h req=%0h", nm, act, req);
        end
    endtask

    task automatic fill_seq(input int cnt);
        for (int i = 0; i < 64; i++) begin
            mem[i] = (i < cnt) ? 32'(i) : 32'h7000_0000;
        end
    endtask

    task automatic push4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic go(input logic [8:0] r, input logic [8:0] c,
                      input logic [31:0] b);
        done_cnt = 0;
        ov_cnt   = 0;
        row_in   = r;
        col_in   = c;
        bias_in  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input bit chk5);
        int  k;
        int  a;
        bit  addr_ok;
        k = 0;
        addr_ok = 1'b1;
        while (done_cnt == 0 && k < 400) begin
            @(posedge clk); #1;
            k++;
            a = int'(rd_addr);
            if (chk5 && busy && ((a % 5) == 4 || (a / 5) == 4)) addr_ok = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 64'(done_cnt), 64'd1);
        check("busy_low", 64'(busy), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        if (chk5) check("addr_5x5_skip", 64'(addr_ok), 64'd1);
    endtask

    task automatic wait_valid();
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        row_in = '0;
        col_in = '0;
        bias_in = '0;
        fill_seq(16);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x4 ramp, bias 0, with latency and ignored mid-pass start
        push4(32'd5, 32'd7, 32'd13, 32'd15);
        go(9'd4, 9'd4, 32'd0);
        check("busy_rise", 64'(busy), 64'd1);
        wait_valid();
        check("first_latency", 64'(n), 64'd6);
        row_in = 9'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0);

        push4(32'd0, 32'd0, 32'd3, 32'd5);
        go(9'd4, 9'd4, 32'hFFFF_FFF6);
        wait_done(1'b0);

        push4(32'd0, 32'd0, 32'd0, 32'd0);
        go(9'd4, 9'd4, 32'hFFFF_FFEC);
        wait_done(1'b0);

        // 5x5: odd last row/column dropped
        fill_seq(25);
        push4(32'd6, 32'd8, 32'd16, 32'd18);
        go(9'd5, 9'd5, 32'd0);
        wait_done(1'b1);

        // Backpressure on the first pixel
        fill_seq(16);
        push4(32'd5, 32'd7, 32'd13, 32'd15);
        out_ready = 1'b0;
        go(9'd4, 9'd4, 32'd0);
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", 64'(out_valid), 64'd1);
            check("bp_data_hold", 64'(out_data), 64'd5);
            check("bp_addr_hold", 64'(rd_addr), 64'd5);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_xfer_valid", 64'(out_valid), 64'd0);
        check("bp_xfer_pop", 64'(exp_q.size()), 64'd3);
        wait_done(1'b0);

        // Saturation both ways and signed max
        mem[0] = 32'h7FFF_FFF0;
        mem[1] = 32'd0;
        mem[2] = 32'd0;
        mem[3] = 32'd0;
        exp_q.push_back(32'h7FFF_FFFF);
        go(9'd2, 9'd2, 32'h0000_0100);
        wait_done(1'b0);

        for (int i = 0; i < 4; i++) mem[i] = 32'h8000_0000;
        exp_q.push_back(32'd0);
        go(9'd2, 9'd2, 32'hFFFF_FFFF);
        wait_done(1'b0);

        mem[0] = 32'hFFFF_FFFB;
        mem[1] = 32'd3;
        mem[2] = 32'hFFFF_FFF8;
        mem[3] = 32'hFFFF_FFFF;
        exp_q.push_back(32'd13);
        go(9'd2, 9'd2, 32'd10);
        wait_done(1'b0);

        // Degenerate map, start in the done cycle ignored
        go(9'd1, 9'd4, 32'd0);
        check("deg_busy", 64'(busy), 64'd1);
        check("deg_done_early", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("deg_done", 64'(done), 64'd1);
        check("deg_busy_drop", 64'(busy), 64'd0);
        row_in = 9'd2;
        col_in = 9'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("deg_done_clear", 64'(done), 64'd0);
        check("start_at_done_ign", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("deg_no_valid", 64'(ov_cnt), 64'd0);
        check("deg_done_count", 64'(done_cnt), 64'd1);

        // Asynchronous reset mid-pass, then a fresh pass
        fill_seq(16);
        push4(32'd5, 32'd7, 32'd13, 32'd15);
        out_ready = 1'b0;
        go(9'd4, 9'd4, 32'd0);
        wait_valid();
        #3 rst_n = 1'b0;
        #1;
        check("arst_rd_addr", 64'(rd_addr), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_no_done", 64'(done_cnt), 64'd0);
        out_ready = 1'b1;
        push4(32'd5, 32'd7, 32'd13, 32'd15);
        go(9'd4, 9'd4, 32'd0);
        wait_done(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_pool_relu.md
Name: conv_pool_relu

Overview:
Post-processing stage directly downstream of the convolution accumulator. After all channel groups have been accumulated into the partial-sum distributed RAM, this block reads the finished row-major result map. It applies 2x2 stride-2 max pooling, adds a per-map bias with signed saturation, and applies ReLU. Pooled pixels leave as a valid/ready stream for the next layer's loader.

Parameters:
DataWidth, 32, width of RAM words, bias and output (signed two's complement)
AddrWidth, 16, RAM read address width
MaxPictWidth, 9, width of row/col dimension inputs
RdLatency, 1, cycles from rd_addr presented to rd_data valid (1 = registered-output DisRAM)

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins one pooling pass (ignored while busy)
row_in  in  MaxPictWidth  result-map rows R, sampled on start
col_in  in  MaxPictWidth  result-map columns W, sampled on start
bias_in  in  DataWidth  signed bias, sampled on start
rd_addr  out  AddrWidth  partial-sum RAM read address
rd_data  in  DataWidth  partial-sum RAM read data (signed)
out_data  out  DataWidth  pooled, biased, ReLU'd pixel
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when out_valid && out_ready
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (Rst low, async): state IDLE. rd_addr, out_data, out_valid, busy and done are all 0. Latched dims, bias and counters are cleared.
- Map layout: element (r,c) is at address r*W+c. Output dims are PR=floor(R/2), PC=floor(C/2). An odd last row or column is dropped.
- No multiplier is used. The row base address advances by 2W per pooled row, and the column offset advances by 2 per pooled column. Addresses are truncated to AddrWidth.
- FSM states: IDLE, READ, DRAIN, CALC, OUT, FIN.
- IDLE:
  - On start, latch R, W and bias, and clear pr/pc.
  - If R<2 or W<2, go to FIN.
  - Otherwise go to READ. busy goes high the cycle after start.
- READ: lasts 4 cycles, issuing base, base+1, base+W, base+W+1 on consecutive cycles (k=0..3). rd_data for an address issued in cycle t is sampled at t+RdLatency.
- DRAIN: waits until all 4 samples are captured, then goes to CALC. The running max is signed: the first sample loads it, and later samples replace it when strictly greater.
- CALC (1 cycle):
  - sum = max + bias, computed at DataWidth+1 bits and saturated to the signed DataWidth range.
  - result = (sum < 0) ? 0 : sum. Register out_data and set out_valid; go to OUT.
- OUT:
  - out_data and out_valid hold stable while out_ready is low.
  - On handshake, drop out_valid the next cycle unless a new pixel is ready, and advance pc. When pc wraps at PC, reset pc to 0 and increment pr.
  - If the last pixel (pr=PR-1, pc=PC-1) is accepted, go to FIN. Otherwise go to READ.
- FIN: pulse done for 1 cycle, drop busy in the same cycle, and return to IDLE.
- Latency: first out_valid appears 4+RdLatency+1 cycles after entering READ. Throughput is at most one pixel per 6+RdLatency cycles with out_ready held high.
- start during busy is ignored. start in the same cycle as done/FIN is also ignored.
- rd_addr holds its last value outside READ. No reads are issued outside READ.
- Reset asserted mid-pass aborts immediately with no done pulse.
- out_ready high while out_valid is low has no effect.

Test Plan:
- 4x4 map holding 0..15 row-major, bias 0, out_ready high -> outputs 5,7,13,15 in order, then a single done pulse; busy low afterwards.
- Same map, bias -10 -> outputs 0,0,3,5. Bias -20 -> outputs 0,0,0,0 (4 handshakes still occur).
- 5x5 map holding 0..24 -> exactly 4 outputs, 6,8,16,18; addresses in row 4 and column 4 are never issued on rd_addr.
- Backpressure: out_ready low for 3 cycles while out_valid is high -> out_data stable, no address advance; the pixel transfers on the cycle out_ready rises.
- Saturation: window {0x7FFFFFF0,0,0,0}, bias 0x100 -> 0x7FFFFFFF. Window of all 0x80000000, bias -1 -> 0.
- Degenerate and reset: row_in=1 -> done pulses 1 cycle after busy with no out_valid. Rst low mid-pass -> all outputs 0 asynchronously, no done; a fresh start works normally.
